// File: rtl/gba_gpu_timing_gen.sv
// GBA GPU display timing generator.
// Walks the four display phases (visible, hblank, vblank, vblank+hblank) from
// a CPU-cycle accumulator, keeps the line counter, pixel position and status
// flags, and produces the single-cycle trigger and IRQ pulses for the renderer,
// DMA and interrupt logic. All outputs come straight from flops.
module gba_gpu_timing_gen #(
    parameter int H_DRAW         = 1008,
    parameter int H_BLANK        = 224,
    parameter int V_DRAW         = 160,
    parameter int V_TOTAL        = 228,
    parameter int DRAW_START     = 160,
    parameter int VRAM_BLOCK_END = 980,
    parameter int VDMA_FIRST     = 2,
    parameter int VDMA_LAST      = 162,
    parameter int STEP_W         = 8,
    parameter int CNT_W          = 12
) (
    input  logic              fclk,
    input  logic              reset,
    input  logic              tick_valid,
    input  logic [STEP_W-1:0] tick_cycles,
    input  logic              lockspeed,
    input  logic              vram_block_mode,
    input  logic              hblank_irq_en,
    input  logic              vblank_irq_en,
    input  logic              vcount_irq_en,
    input  logic [7:0]        vcount_setting,
    output logic              flag_hblank,
    output logic              flag_vblank,
    output logic              flag_vcount,
    output logic              irq_hblank,
    output logic              irq_vblank,
    output logic              irq_vcount,
    output logic [7:0]        vcount,
    output logic [8:0]        pixelpos,
    output logic [1:0]        state,
    output logic              line_trigger,
    output logic              hblank_trigger,
    output logic              vblank_trigger,
    output logic              drawline,
    output logic              refpoint_update,
    output logic              newline_invsync,
    output logic              videodma_start,
    output logic              videodma_stop,
    output logic              vram_blocked
);

    typedef enum logic [1:0] {
        ST_VISIBLE      = 2'd0,
        ST_HBLANK       = 2'd1,
        ST_VBLANK       = 2'd2,
        ST_VBLANKHBLANK = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  acc_r, acc_s, acc_sum_s, half_s;
    logic [7:0]        vcount_r, vcount_s, line_inc_s;
    logic [8:0]        pixelpos_r, pixelpos_s;
    logic              drawsoon_r, drawsoon_s;
    logic              flag_hblank_r, flag_hblank_s;
    logic              flag_vblank_r, flag_vblank_s;
    logic              flag_vcount_r, flag_vcount_s;
    logic              irq_hblank_r, irq_hblank_s;
    logic              irq_vblank_r, irq_vblank_s;
    logic              irq_vcount_r, irq_vcount_s;
    logic              line_trigger_r, line_trigger_s;
    logic              hblank_trigger_r, hblank_trigger_s;
    logic              vblank_trigger_r, vblank_trigger_s;
    logic              drawline_r, drawline_s;
    logic              refpoint_update_r, refpoint_update_s;
    logic              newline_invsync_r, newline_invsync_s;
    logic              videodma_start_r, videodma_start_s;
    logic              videodma_stop_r, videodma_stop_s;
    logic              vram_blocked_r, vram_blocked_s;

    // Next-state, counter and pulse decode: at most one phase change per clock,
    // threshold subtracted so any overshoot carries into the next phase.
    always_comb begin
        acc_sum_s         = acc_r + (tick_valid ? CNT_W'(tick_cycles) : {CNT_W{1'b0}});
        half_s            = acc_sum_s >> 1;
        line_inc_s        = vcount_r + 8'd1;
        state_s           = state_r;
        acc_s             = acc_sum_s;
        vcount_s          = vcount_r;
        pixelpos_s        = pixelpos_r;
        drawsoon_s        = drawsoon_r;
        flag_hblank_s     = flag_hblank_r;
        flag_vblank_s     = flag_vblank_r;
        flag_vcount_s     = flag_vcount_r;
        irq_hblank_s      = 1'b0;
        irq_vblank_s      = 1'b0;
        irq_vcount_s      = 1'b0;
        line_trigger_s    = 1'b0;
        hblank_trigger_s  = 1'b0;
        vblank_trigger_s  = 1'b0;
        drawline_s        = 1'b0;
        refpoint_update_s = 1'b0;
        newline_invsync_s = 1'b0;
        videodma_start_s  = 1'b0;
        videodma_stop_s   = 1'b0;

        case (state_r)
            ST_VISIBLE: begin
                // A pending draw fires at once unless tracking real pixel position.
                if (drawsoon_r && (!lockspeed || (acc_sum_s >= CNT_W'(DRAW_START)))) begin
                    drawline_s = 1'b1;
                    drawsoon_s = 1'b0;
                end else begin
                    drawsoon_s = drawsoon_r;
                end
                if (lockspeed && (acc_sum_s >= CNT_W'(DRAW_START))) begin
                    pixelpos_s = 9'(half_s - CNT_W'(DRAW_START / 2));
                end else begin
                    pixelpos_s = pixelpos_r;
                end
                if (acc_sum_s >= CNT_W'(H_DRAW)) begin
                    state_s          = ST_HBLANK;
                    acc_s            = acc_sum_s - CNT_W'(H_DRAW);
                    flag_hblank_s    = 1'b1;
                    hblank_trigger_s = 1'b1;
                    pixelpos_s       = 9'd240;
                    irq_hblank_s     = hblank_irq_en;
                    videodma_start_s = (vcount_r >= 8'(VDMA_FIRST));
                end else begin
                    state_s = ST_VISIBLE;
                end
            end
            ST_HBLANK: begin
                if (acc_sum_s >= CNT_W'(H_BLANK)) begin
                    acc_s         = acc_sum_s - CNT_W'(H_BLANK);
                    vcount_s      = line_inc_s;
                    flag_hblank_s = 1'b0;
                    flag_vcount_s = (line_inc_s == vcount_setting);
                    irq_vcount_s  = vcount_irq_en && (line_inc_s == vcount_setting);
                    if (line_inc_s < 8'(V_DRAW)) begin
                        state_s        = ST_VISIBLE;
                        line_trigger_s = 1'b1;
                        pixelpos_s     = 9'd0;
                        drawsoon_s     = 1'b1;
                    end else begin
                        state_s           = ST_VBLANK;
                        flag_vblank_s     = 1'b1;
                        vblank_trigger_s  = 1'b1;
                        refpoint_update_s = 1'b1;
                        irq_vblank_s      = vblank_irq_en;
                    end
                end else begin
                    state_s = ST_HBLANK;
                end
            end
            ST_VBLANK: begin
                if (acc_sum_s >= CNT_W'(H_DRAW)) begin
                    state_s           = ST_VBLANKHBLANK;
                    acc_s             = acc_sum_s - CNT_W'(H_DRAW);
                    flag_hblank_s     = 1'b1;
                    newline_invsync_s = 1'b1;
                    irq_hblank_s      = hblank_irq_en;
                    videodma_start_s  = (vcount_r < 8'(VDMA_LAST));
                    videodma_stop_s   = (vcount_r == 8'(VDMA_LAST));
                end else begin
                    state_s = ST_VBLANK;
                end
            end
            ST_VBLANKHBLANK: begin
                if (acc_sum_s >= CNT_W'(H_BLANK)) begin
                    acc_s          = acc_sum_s - CNT_W'(H_BLANK);
                    flag_hblank_s  = 1'b0;
                    line_trigger_s = 1'b1;
                    if (line_inc_s == 8'(V_TOTAL)) begin
                        vcount_s      = 8'd0;
                        state_s       = ST_VISIBLE;
                        pixelpos_s    = 9'd0;
                        drawsoon_s    = 1'b1;
                        flag_vcount_s = (vcount_setting == 8'd0);
                    end else begin
                        vcount_s      = line_inc_s;
                        state_s       = ST_VBLANK;
                        flag_vcount_s = (line_inc_s == vcount_setting);
                        if (line_inc_s == 8'(V_TOTAL - 1)) begin
                            flag_vblank_s = 1'b0;
                        end else begin
                            flag_vblank_s = flag_vblank_r;
                        end
                    end
                    irq_vcount_s = vcount_irq_en && flag_vcount_s;
                end else begin
                    state_s = ST_VBLANKHBLANK;
                end
            end
            default: begin
                state_s = ST_VISIBLE;
                acc_s   = {CNT_W{1'b0}};
            end
        endcase

        // Evaluated on the post-edge phase/accumulator so the level lines up
        // with the state and counter values it describes.
        vram_blocked_s = (state_s == ST_VISIBLE) && vram_block_mode &&
                         (acc_s < CNT_W'(VRAM_BLOCK_END));
    end

    // Timing state, counters, flags and pulse registers.
    always_ff @(posedge fclk or posedge reset) begin
        if (reset) begin
            state_r           <= ST_VISIBLE;
            acc_r             <= {CNT_W{1'b0}};
            vcount_r          <= 8'd0;
            pixelpos_r        <= 9'd0;
            drawsoon_r        <= 1'b0;
            flag_hblank_r     <= 1'b0;
            flag_vblank_r     <= 1'b0;
            flag_vcount_r     <= 1'b0;
            irq_hblank_r      <= 1'b0;
            irq_vblank_r      <= 1'b0;
            irq_vcount_r      <= 1'b0;
            line_trigger_r    <= 1'b0;
            hblank_trigger_r  <= 1'b0;
            vblank_trigger_r  <= 1'b0;
            drawline_r        <= 1'b0;
            refpoint_update_r <= 1'b0;
            newline_invsync_r <= 1'b0;
            videodma_start_r  <= 1'b0;
            videodma_stop_r   <= 1'b0;
            vram_blocked_r    <= 1'b0;
        end else begin
            state_r           <= state_s;
            acc_r             <= acc_s;
            vcount_r          <= vcount_s;
            pixelpos_r        <= pixelpos_s;
            drawsoon_r        <= drawsoon_s;
            flag_hblank_r     <= flag_hblank_s;
            flag_vblank_r     <= flag_vblank_s;
            flag_vcount_r     <= flag_vcount_s;
            irq_hblank_r      <= irq_hblank_s;
            irq_vblank_r      <= irq_vblank_s;
            irq_vcount_r      <= irq_vcount_s;
            line_trigger_r    <= line_trigger_s;
            hblank_trigger_r  <= hblank_trigger_s;
            vblank_trigger_r  <= vblank_trigger_s;
            drawline_r        <= drawline_s;
            refpoint_update_r <= refpoint_update_s;
            newline_invsync_r <= newline_invsync_s;
            videodma_start_r  <= videodma_start_s;
            videodma_stop_r   <= videodma_stop_s;
            vram_blocked_r    <= vram_blocked_s;
        end
    end

    assign state           = state_r;
    assign vcount          = vcount_r;
    assign pixelpos        = pixelpos_r;
    assign flag_hblank     = flag_hblank_r;
    assign flag_vblank     = flag_vblank_r;
    assign flag_vcount     = flag_vcount_r;
    assign irq_hblank      = irq_hblank_r;
    assign irq_vblank      = irq_vblank_r;
    assign irq_vcount      = irq_vcount_r;
    assign line_trigger    = line_trigger_r;
    assign hblank_trigger  = hblank_trigger_r;
    assign vblank_trigger  = vblank_trigger_r;
    assign drawline        = drawline_r;
    assign refpoint_update = refpoint_update_r;
    assign newline_invsync = newline_invsync_r;
    assign videodma_start  = videodma_start_r;
    assign videodma_stop   = videodma_stop_r;
    assign vram_blocked    = vram_blocked_r;

endmodule

// File: tb/tb_gba_gpu_timing_gen.sv
// Self-checking bench for gba_gpu_timing_gen: directed timing scenarios plus a
// randomized run, all compared every cycle against a line/phase reference model.
module tb_gba_gpu_timing_gen;

    logic       fclk = 1'b0;
    logic       reset;
    logic       tick_valid;
    logic [7:0] tick_cycles;
    logic       lockspeed, vram_block_mode;
    logic       hblank_irq_en, vblank_irq_en, vcount_irq_en;
    logic [7:0] vcount_setting;
    logic       flag_hblank, flag_vblank, flag_vcount;
    logic       irq_hblank, irq_vblank, irq_vcount;
    logic [7:0] vcount;
    logic [8:0] pixelpos;
    logic [1:0] state;
    logic       line_trigger, hblank_trigger, vblank_trigger, drawline;
    logic       refpoint_update, newline_invsync, videodma_start, videodma_stop;
    logic       vram_blocked;

    gba_gpu_timing_gen dut (
        .fclk(fclk), .reset(reset), .tick_valid(tick_valid), .tick_cycles(tick_cycles),
        .lockspeed(lockspeed), .vram_block_mode(vram_block_mode),
        .hblank_irq_en(hblank_irq_en), .vblank_irq_en(vblank_irq_en),
        .vcount_irq_en(vcount_irq_en), .vcount_setting(vcount_setting),
        .flag_hblank(flag_hblank), .flag_vblank(flag_vblank), .flag_vcount(flag_vcount),
        .irq_hblank(irq_hblank), .irq_vblank(irq_vblank), .irq_vcount(irq_vcount),
        .vcount(vcount), .pixelpos(pixelpos), .state(state),
        .line_trigger(line_trigger), .hblank_trigger(hblank_trigger),
        .vblank_trigger(vblank_trigger), .drawline(drawline),
        .refpoint_update(refpoint_update), .newline_invsync(newline_invsync),
        .videodma_start(videodma_start), .videodma_stop(videodma_stop),
        .vram_blocked(vram_blocked)
    );

    always #5 fclk = ~fclk;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;

    // Reference model: phase numbers follow the state output encoding.
    localparam int P_VIS = 0, P_HB = 1, P_VB = 2, P_VBHB = 3;
    int m_phase, m_acc, m_line, m_pix;
    bit m_drawsoon, m_fh, m_fv, m_fvc;
    bit e_ih, e_iv, e_ivc, e_lt, e_hbt, e_vbt, e_draw, e_ref, e_nis, e_dstart, e_dstop, e_vb;

    task automatic model_reset();
        m_phase = P_VIS; m_acc = 0; m_line = 0; m_pix = 0;
        m_drawsoon = 0; m_fh = 0; m_fv = 0; m_fvc = 0;
        {e_ih, e_iv, e_ivc, e_lt, e_hbt, e_vbt, e_draw, e_ref, e_nis, e_dstart, e_dstop, e_vb} = '0;
    endtask

    task automatic model_enter_line(int n);
        m_line = n;
        m_fvc  = (n == int'(vcount_setting));
        e_ivc  = m_fvc && vcount_irq_en;
    endtask

    // One clock of the display timing, from the documented phase rules.
    task automatic model_clock();
        int a, thr;
        {e_ih, e_iv, e_ivc, e_lt, e_hbt, e_vbt, e_draw, e_ref, e_nis, e_dstart, e_dstop} = '0;
        a   = m_acc + (tick_valid ? int'(tick_cycles) : 0);
        thr = (m_phase == P_HB || m_phase == P_VBHB) ? 224 : 1008;
        if (m_phase == P_VIS) begin
            if (m_drawsoon && (!lockspeed || a >= 160)) begin
                e_draw = 1; m_drawsoon = 0;
            end
            if (lockspeed && a >= 160) m_pix = a / 2 - 80;
        end
        if (a >= thr) begin
            a = a - thr;
            case (m_phase)
                P_VIS: begin
                    m_phase = P_HB; m_fh = 1; e_hbt = 1; m_pix = 240;
                    e_ih = hblank_irq_en; e_dstart = (m_line >= 2);
                end
                P_HB: begin
                    m_fh = 0;
                    model_enter_line(m_line + 1);
                    if (m_line < 160) begin
                        m_phase = P_VIS; e_lt = 1; m_pix = 0; m_drawsoon = 1;
                    end else begin
                        m_phase = P_VB; m_fv = 1; e_vbt = 1; e_ref = 1; e_iv = vblank_irq_en;
                    end
                end
                P_VB: begin
                    m_phase = P_VBHB; m_fh = 1; e_nis = 1; e_ih = hblank_irq_en;
                    e_dstart = (m_line < 162); e_dstop = (m_line == 162);
                end
                default: begin
                    m_fh = 0; e_lt = 1;
                    model_enter_line((m_line + 1) % 228);
                    if (m_line == 0) begin
                        m_phase = P_VIS; m_pix = 0; m_drawsoon = 1;
                    end else begin
                        m_phase = P_VB;
                        if (m_line == 227) m_fv = 0;
                    end
                end
            endcase
        end
        m_acc = a;
        e_vb  = vram_block_mode && (m_phase == P_VIS) && (m_acc < 980);
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, ncyc, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_phase));
        chk({tag, ".vcount"}, 32'(vcount), 32'(m_line));
        chk({tag, ".pixelpos"}, 32'(pixelpos), 32'(m_pix));
        chk({tag, ".flags"}, 32'({flag_hblank, flag_vblank, flag_vcount}), 32'({m_fh, m_fv, m_fvc}));
        chk({tag, ".pulses"},
            32'({irq_hblank, irq_vblank, irq_vcount, line_trigger, hblank_trigger, vblank_trigger,
                 drawline, refpoint_update, newline_invsync, videodma_start, videodma_stop}),
            32'({e_ih, e_iv, e_ivc, e_lt, e_hbt, e_vbt, e_draw, e_ref, e_nis, e_dstart, e_dstop}));
        chk({tag, ".vram_blocked"}, 32'(vram_blocked), 32'(e_vb));
    endtask

    // Inputs are already set; predict the next edge, then compare after it.
    task automatic cyc(string tag);
        model_clock();
        @(negedge fclk);
        ncyc++;
        check_all(tag);
    endtask

    // Asynchronous reset pulse starting mid-cycle; outputs must clear at once.
    task automatic pulse_reset(string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, ".all_outputs_zero"},
            32'({flag_hblank, flag_vblank, flag_vcount, irq_hblank, irq_vblank, irq_vcount,
                 vcount, state, line_trigger, hblank_trigger, vblank_trigger, drawline,
                 refpoint_update, newline_invsync, videodma_start, videodma_stop, vram_blocked}),
            32'd0);
        chk({tag, ".pixelpos_zero"}, 32'(pixelpos), 32'd0);
        model_reset();
        @(negedge fclk);
        reset = 1'b0;
        check_all(tag);
    endtask

    initial begin
        int hb_at, lt_at, lt_line, total;
        int st [1:12];
        int vb_st [1:12];
        int at_vbt, vbt_line, vbt_irq, at_ivc, at_fvc_fall, at_fv_fall, at_wrap;
        bit prev_fvc, prev_fv, did_rst;

        reset = 1'b1; tick_valid = 1'b0; tick_cycles = 8'd0; lockspeed = 1'b0;
        vram_block_mode = 1'b1; hblank_irq_en = 1'b1; vblank_irq_en = 1'b1;
        vcount_irq_en = 1'b1; vcount_setting = 8'd1;
        model_reset();
        @(negedge fclk);
        check_all("reset");
        reset = 1'b0;

        // Single-cycle steps across the first line.
        tick_valid = 1'b1; tick_cycles = 8'd1;
        hb_at = 0; lt_at = 0; lt_line = 0; total = 0;
        for (int i = 0; i < 1300; i++) begin
            cyc("step1");
            total++;
            if (hblank_trigger && hb_at == 0) hb_at = total;
            if (line_trigger && lt_at == 0) begin
                lt_at = total; lt_line = int'(vcount);
            end
        end
        chk("step1.hblank_at", 32'(hb_at), 32'd1008);
        chk("step1.line_at", 32'(lt_at), 32'd1232);
        chk("step1.new_line", 32'(lt_line), 32'd1);

        // Large steps: carry across transitions, one transition per clock.
        pulse_reset("rst_a");
        tick_cycles = 8'd200;
        for (int i = 1; i <= 12; i++) begin
            cyc("step200");
            st[i] = int'(state);
            vb_st[i] = int'(vram_blocked);
        end
        chk("step200.st5_visible", 32'(st[5]), 32'd0);
        chk("step200.st6_hblank", 32'(st[6]), 32'd1);
        chk("step200.st7_visible", 32'(st[7]), 32'd0);
        chk("step200.st11_visible", 32'(st[11]), 32'd0);
        chk("step200.st12_hblank", 32'(st[12]), 32'd1);
        chk("step200.vram_acc800", 32'(vb_st[4]), 32'd1);
        chk("step200.vram_acc1000", 32'(vb_st[5]), 32'd0);
        chk("step200.vram_hblank", 32'(vb_st[6]), 32'd0);
        chk("step200.vram_acc168", 32'(vb_st[7]), 32'd1);

        // Whole frame with 112-cycle steps: 11 strobes per line, no carry.
        pulse_reset("rst_b");
        tick_cycles = 8'd112; vcount_setting = 8'd100; hblank_irq_en = 1'b0;
        at_vbt = 0; vbt_line = 0; vbt_irq = 0; at_ivc = 0; at_fvc_fall = 0;
        at_fv_fall = 0; at_wrap = 0;
        for (int i = 1; i <= 2600; i++) begin
            prev_fvc = flag_vcount; prev_fv = flag_vblank;
            cyc("frame");
            if (vblank_trigger && at_vbt == 0) begin
                at_vbt = i; vbt_line = int'(vcount); vbt_irq = int'(irq_vblank);
            end
            if (irq_vcount && at_ivc == 0) at_ivc = i;
            if (prev_fvc && !flag_vcount && at_fvc_fall == 0) at_fvc_fall = i;
            if (prev_fv && !flag_vblank && at_fv_fall == 0) at_fv_fall = i;
            if (line_trigger && vcount == 8'd0 && at_wrap == 0) at_wrap = i;
            if (at_wrap != 0) break;
        end
        chk("frame.vblank_at", 32'(at_vbt), 32'd1760);
        chk("frame.vblank_line", 32'(vbt_line), 32'd160);
        chk("frame.vblank_irq", 32'(vbt_irq), 32'd1);
        chk("frame.vcount_irq_at", 32'(at_ivc), 32'd1100);
        chk("frame.vcount_flag_fall", 32'(at_fvc_fall), 32'd1111);
        chk("frame.vblank_flag_fall", 32'(at_fv_fall), 32'd2497);
        chk("frame.wrap_at", 32'(at_wrap), 32'd2508);

        // Randomized traffic, with one reset landing on line 50.
        pulse_reset("rst_c");
        did_rst = 1'b0;
        vcount_setting = 8'd0;
        for (int i = 0; i < 3500; i++) begin
            tick_valid  = ($urandom_range(0, 9) != 0);
            tick_cycles = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 199) == 0) lockspeed = ~lockspeed;
            if ($urandom_range(0, 199) == 0) vram_block_mode = ~vram_block_mode;
            if ($urandom_range(0, 99) == 0)
                {hblank_irq_en, vblank_irq_en, vcount_irq_en} = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0)
                vcount_setting = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 227));
            if (!did_rst && vcount == 8'd50) begin
                did_rst = 1'b1;
                pulse_reset("rst_line50");
            end else begin
                cyc("random");
            end
        end
        chk("random.reset_seen", 32'(did_rst), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gba_gpu_timing_gen.md
GBA_GPU_TIMING_GEN -- requirements
Module: gba_gpu_timing_gen

Interface
REQ-001 SHALL have parameters H_DRAW=1008, H_BLANK=224, V_DRAW=160, V_TOTAL=228, DRAW_START=160, VRAM_BLOCK_END=980, VDMA_FIRST=2, VDMA_LAST=162, STEP_W=8, CNT_W=12.
REQ-002 SHALL have ports:
- fclk  in  1  sole clock
- reset  in  1  asynchronous, active-high
- tick_valid  in  1  CPU-cycle advance strobe
- tick_cycles  in  STEP_W  cycles to add when tick_valid=1
- lockspeed  in  1  pixel-position tracking enable
- vram_block_mode  in  1  VRAM-block window enable
- hblank_irq_en, vblank_irq_en, vcount_irq_en  in  1 each  IRQ enables
- vcount_setting  in  8  V-count match line
- flag_hblank, flag_vblank, flag_vcount  out  1 each  status flags
- irq_hblank, irq_vblank, irq_vcount  out  1 each  one-cycle IRQ pulses
- vcount  out  8  current line, 0..V_TOTAL-1
- pixelpos  out  9  horizontal pixel position
- state  out  2  0 VISIBLE, 1 HBLANK, 2 VBLANK, 3 VBLANKHBLANK
- line_trigger, hblank_trigger, vblank_trigger, drawline, refpoint_update, newline_invsync, videodma_start, videodma_stop  out  1 each  one-cycle pulses
- vram_blocked  out  1  registered VRAM-block level

Function
REQ-003 The cycle accumulator (CNT_W bits) SHALL add tick_cycles on each fclk where tick_valid=1; the comparisons in REQ-005..REQ-009 use the post-add value in the same cycle.
REQ-004 At most one state transition SHALL occur per fclk; on a transition the threshold is subtracted and the excess is carried, never discarded.
REQ-005 VISIBLE: when acc>=H_DRAW -> HBLANK, flag_hblank=1, hblank_trigger, pixelpos=240, irq_hblank if hblank_irq_en, videodma_start if vcount>=VDMA_FIRST.
REQ-006 HBLANK: when acc>=H_BLANK -> vcount+1, flag_hblank=0; if the new line <V_DRAW: VISIBLE, line_trigger, pixelpos=0, arm drawsoon; else VBLANK, flag_vblank=1, vblank_trigger, refpoint_update, irq_vblank if vblank_irq_en.
REQ-007 VBLANK: when acc>=H_DRAW -> VBLANKHBLANK, flag_hblank=1, newline_invsync, irq_hblank if hblank_irq_en; videodma_start if vcount<VDMA_LAST; videodma_stop if vcount==VDMA_LAST; no hblank_trigger.
REQ-008 VBLANKHBLANK: when acc>=H_BLANK -> flag_hblank=0, line_trigger; if vcount+1==V_TOTAL: vcount=0, VISIBLE, pixelpos=0, arm drawsoon; else vcount+1, VBLANK; flag_vblank=0 when the new line ==V_TOTAL-1.
REQ-009 drawline SHALL pulse once per armed drawsoon in VISIBLE: immediately when lockspeed=0, else once acc>=DRAW_START; with lockspeed=1 and acc>=DRAW_START, pixelpos=(acc>>1)-DRAW_START/2.
REQ-010 On every line increment, flag_vcount SHALL equal (new line==vcount_setting), or 1 on wrap to 0 when vcount_setting==0; irq_vcount pulses on that cycle if flag_vcount goes 1 and vcount_irq_en=1.
REQ-011 vram_blocked SHALL equal the registered value of (state==VISIBLE & vram_block_mode & acc<VRAM_BLOCK_END).
REQ-012 All pulse outputs SHALL default to 0 on every cycle they are not asserted.
REQ-013 Changes to vcount_setting or the IRQ enables SHALL take effect at the next evaluation, without retroactive pulses.

Reset
REQ-014 While reset=1: state=VISIBLE, acc=0, vcount=0, pixelpos=0, drawsoon=0, all flags=0, all pulses=0, vram_blocked=0.
REQ-015 Asserting reset mid-line SHALL abort immediately; after release, counting restarts at line 0 VISIBLE with no leftover pulses.

Verification
REQ-016 Steps of 1 cycle per fclk, default parameters -> hblank_trigger at accumulated cycle 1008, line_trigger at 1232, vcount 0->1.
REQ-017 One full frame -> vblank_trigger and irq_vblank (vblank_irq_en=1) at line 160; flag_vblank cleared entering line 227; vcount wraps 227->0 after 280896 cycles.
REQ-018 tick_cycles=200 per strobe -> transition at acc 1200, carry 192, then HBLANK->VISIBLE on the next strobe (392>=224) with carry 168; one transition per cycle.
REQ-019 vcount_setting=0, vcount_irq_en=1 -> irq_vcount and flag_vcount on wrap to line 0 only; vcount_setting=100 -> pulse entering line 100, flag cleared entering line 101.
REQ-020 vram_block_mode=1 -> vram_blocked=1 for acc<980 in VISIBLE, 0 in HBLANK and VBLANK; reset asserted at line 50 -> all outputs are at reset values the same cycle.
